// File: rtl/song_reader.sv
// song_reader: walks one song's ROM entries, strobing each {note, duration} to the note player
module song_reader #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_player,
    input  logic                    play,
    input  logic [1:0]              song,
    input  logic                    note_done,
    output logic [2+IDX_W-1:0]      rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note,
    output logic [DUR_W-1:0]        duration,
    output logic                    new_note,
    output logic                    song_done
);
    typedef enum logic [2:0] {
        S_FETCH, S_WAIT_ROM, S_NOTE_OUT, S_WAIT_DONE, S_DONE, S_END
    } state_t;
    state_t state, next_state;
    logic [IDX_W-1:0] idx;
    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0] rom_dur;
    logic last_idx;
    assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];
    assign last_idx = idx == {IDX_W{1'b1}};
    assign rom_addr = {song, idx};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            idx      <= '0;
            note     <= '0;
            duration <= '0;
        end else if (reset_player) begin
            state    <= S_FETCH;
            idx      <= '0;
            note     <= '0;
            duration <= '0;
        end else begin
            state <= next_state;
            if (state == S_WAIT_ROM && rom_dur != '0) begin
                note     <= rom_note;
                duration <= rom_dur;
            end
            if (state == S_WAIT_DONE && note_done && !last_idx)
                idx <= idx + 1'b1;
        end
    end
    // a zero duration is the end-of-song marker; the last index also ends the song
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:     next_state = play ? S_WAIT_ROM : S_FETCH;
            S_WAIT_ROM:  next_state = (rom_dur == '0) ? S_DONE : S_NOTE_OUT;
            S_NOTE_OUT:  next_state = S_WAIT_DONE;
            S_WAIT_DONE: next_state = note_done ? (last_idx ? S_DONE : S_FETCH) : S_WAIT_DONE;
            S_DONE:      next_state = S_END;
            default:     next_state = S_END;
        endcase
    end
    always_comb begin
        new_note  = state == S_NOTE_OUT;
        song_done = state == S_DONE;
    end
endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: scoreboard bench; a ROM model feeds the reader and expected notes are queued per song
module tb_song_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset_player = 1'b0;
    logic        play = 1'b0;
    logic [1:0]  song = 2'd0;
    logic        note_done = 1'b0;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data = '0;
    logic [5:0]  note, duration;
    logic        new_note, song_done;
    logic [11:0] rom [128];
    logic [11:0] exp_q [$];
    int checks = 0, errors = 0, done_cnt = 0, n;

    song_reader dut (
        .clk(clk), .reset(reset), .reset_player(reset_player), .play(play),
        .song(song), .note_done(note_done), .rom_addr(rom_addr), .rom_data(rom_data),
        .note(note), .duration(duration), .new_note(new_note), .song_done(song_done)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s, input int i);
        exp_q.push_back(rom[s*32+i]);
    endtask

    task automatic wait_new(output int cnt);
        cnt = 0;
        while (!new_note && cnt < 40) begin
            tick();
            cnt++;
        end
        if (!new_note) check("new_note_timeout", 32'(new_note), 1);
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!song_done && cnt < 40) begin
            tick();
            cnt++;
        end
        if (!song_done) check("song_done_timeout", 32'(song_done), 1);
    endtask

    task automatic ack(input int d);
        repeat (d) tick();
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
    endtask

    // scoreboard: every strobe must match the oldest queued entry
    always @(negedge clk) begin
        if (!reset) begin
            if (new_note) begin
                if (exp_q.size() == 0) check("unexpected_note", 32'(exp_q.size()), 1);
                else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    check("note", 32'(note), 32'(e[11:6]));
                    check("duration", 32'(duration), 32'(e[5:0]));
                end
            end
            if (song_done) done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = '0;
        rom[0] = {6'd10, 6'd4};
        rom[1] = {6'd12, 6'd4};
        for (int i = 0; i < 32; i++) begin
            rom[32+i] = {6'(i + 1), 6'(i % 7 + 1)};
            rom[64+i] = {6'(20 + i), 6'd3};
        end
        rom[96] = {6'd41, 6'd2};
        rom[97] = {6'd42, 6'd2};
        #1;
        check("rst_note", 32'(note), 0);
        check("rst_dur", 32'(duration), 0);
        check("rst_new_note", 32'(new_note), 0);
        check("rst_song_done", 32'(song_done), 0);
        check("rst_addr", 32'(rom_addr), 0);
        tick();
        reset = 1'b0;
        play = 1'b1;
        push(0, 0);
        push(0, 1);
        // song 0: two notes then marker
        wait_new(n);
        check("t1_lat_first", n, 2);
        ack(5);
        wait_new(n);
        check("t1_lat_next", n, 2);
        ack(5);
        wait_done(n);
        check("t1_done_lat", n, 2);
        tick();
        check("t1_done_width", 32'(song_done), 0);
        repeat (8) tick();
        check("t1_done_cnt", done_cnt, 1);
        // song 1: 32 entries, no marker
        song = 2'd1;
        reset_player = 1'b1;
        tick();
        reset_player = 1'b0;
        check("t2_addr0", 32'(rom_addr), 32'({2'd1, 5'd0}));
        for (int i = 0; i < 32; i++) begin
            push(1, i);
            wait_new(n);
            check("t2_lat", n, 2);
            check("t2_addr", 32'(rom_addr), 32'({2'd1, 5'(i)}));
            ack(3);
        end
        check("t2_done_now", 32'(song_done), 1);
        repeat (5) begin
            tick();
            check("t2_no_wrap", 32'(rom_addr), 32'({2'd1, 5'd31}));
        end
        check("t2_done_cnt", done_cnt, 2);
        // pause in FETCH
        play = 1'b0;
        song = 2'd2;
        reset_player = 1'b1;
        tick();
        reset_player = 1'b0;
        repeat (10) begin
            tick();
            check("t3_pause_addr", 32'(rom_addr), 32'({2'd2, 5'd0}));
            check("t3_pause_nn", 32'(new_note), 0);
        end
        push(2, 0);
        play = 1'b1;
        wait_new(n);
        check("t3_resume_lat", n, 2);
        // reset_player beats note_done in WAIT_DONE
        push(2, 1);
        ack(2);
        wait_new(n);
        check("t4_lat", n, 2);
        tick();
        push(2, 0);
        reset_player = 1'b1;
        note_done = 1'b1;
        tick();
        reset_player = 1'b0;
        note_done = 1'b0;
        check("t4_addr", 32'(rom_addr), 32'(7'b10_00000));
        check("t4_nn", 32'(new_note), 0);
        wait_new(n);
        check("t4_restart_lat", n, 2);
        tick();
        // mcu answers song_done with reset_player in the same cycle
        song = 2'd3;
        reset_player = 1'b1;
        push(3, 0);
        push(3, 1);
        tick();
        reset_player = 1'b0;
        wait_new(n);
        ack(2);
        wait_new(n);
        ack(2);
        wait_done(n);
        check("t5_done_lat", n, 2);
        reset_player = 1'b1;
        song = 2'd0;
        push(0, 0);
        push(0, 1);
        tick();
        reset_player = 1'b0;
        check("t5_done_width", 32'(song_done), 0);
        check("t5_done_cnt", done_cnt, 3);
        wait_new(n);
        check("t5_restart_lat", n, 2);
        check("t5_addr", 32'(rom_addr), 32'({2'd0, 5'd0}));
        ack(5);
        wait_new(n);
        tick();
        // async reset while waiting on the note player
        #2 reset = 1'b1;
        #1;
        check("t6_note", 32'(note), 0);
        check("t6_dur", 32'(duration), 0);
        check("t6_nn", 32'(new_note), 0);
        check("t6_sd", 32'(song_done), 0);
        push(0, 0);
        tick();
        reset = 1'b0;
        wait_new(n);
        check("t6_restart_lat", n, 2);
        repeat (4) tick();
        check("t6_done_cnt", done_cnt, 3);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
